// File: rtl/fp32_divide.sv
// Sequential binary32 divider: restoring radix-2, one quotient bit per clock.
// Define FP_DIVIDE_RNE_EN for round-to-nearest-even; otherwise truncates.
module fp32_divide (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic        dz,
    output logic        inv
);

    typedef enum logic [2:0] {
        IDLE,
        SPECIAL,
        DIV,
        NORM,
        ROUND
    } state_t;

    state_t state, state_nx;

    logic              sign;
    logic signed [9:0] exp_r;
    logic [23:0]       mb;
    logic [24:0]       rem;
    logic [25:0]       q;
    logic [4:0]        cnt;
    logic [23:0]       mant;
`ifdef FP_DIVIDE_RNE_EN
    logic              guard;
    logic              sticky;
`endif
    logic a_zero, a_inf, a_nan;
    logic b_zero, b_inf, b_nan;

    logic a_zero_c, a_inf_c, a_nan_c;
    logic b_zero_c, b_inf_c, b_nan_c;
    logic special_c;

    logic              ge;
    logic [24:0]       diff;
    logic              inc;
    logic [24:0]       rounded;
    logic [22:0]       frac_f;
    logic signed [9:0] exp_f;
    logic [31:0]       pack;
    logic [31:0]       spec_res;
    logic              spec_dz;
    logic              spec_inv;

    // Exponent 0 means zero regardless of fraction: subnormals are flushed.
    always_comb begin
        a_zero_c  = (a[30:23] == 8'h00);
        a_inf_c   = (a[30:23] == 8'hff) && (a[22:0] == 23'd0);
        a_nan_c   = (a[30:23] == 8'hff) && (a[22:0] != 23'd0);
        b_zero_c  = (b[30:23] == 8'h00);
        b_inf_c   = (b[30:23] == 8'hff) && (b[22:0] == 23'd0);
        b_nan_c   = (b[30:23] == 8'hff) && (b[22:0] != 23'd0);
        special_c = a_zero_c | a_inf_c | a_nan_c
                  | b_zero_c | b_inf_c | b_nan_c;
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (start) state_nx = special_c ? SPECIAL : DIV;
            end
            SPECIAL: state_nx = IDLE;
            DIV: begin
                if (cnt == 5'd25) state_nx = NORM;
            end
            NORM:    state_nx = ROUND;
            ROUND:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        ge   = (rem >= {1'b0, mb});
        diff = ge ? (rem - {1'b0, mb}) : rem;
    end

    always_comb begin
`ifdef FP_DIVIDE_RNE_EN
        inc = guard & (sticky | mant[0]);
`else
        inc = 1'b0;
`endif
        rounded = {1'b0, mant} + {24'd0, inc};
        frac_f  = rounded[24] ? rounded[23:1] : rounded[22:0];
        exp_f   = rounded[24] ? (exp_r + 10'sd1) : exp_r;
        if (exp_f >= 10'sd255)
            pack = {sign, 8'hff, 23'd0};
        else if (exp_f <= 10'sd0)
            pack = {sign, 31'd0};
        else
            pack = {sign, exp_f[7:0], frac_f};
    end

    always_comb begin
        spec_res = {sign, 31'd0};
        spec_dz  = 1'b0;
        spec_inv = 1'b0;
        if (a_nan | b_nan | (a_zero & b_zero) | (a_inf & b_inf)) begin
            spec_res = 32'h7fc00000;
            spec_inv = 1'b1;
        end else if (a_inf) begin
            spec_res = {sign, 8'hff, 23'd0};
        end else if (b_inf) begin
            spec_res = {sign, 31'd0};
        end else if (b_zero) begin
            spec_res = {sign, 8'hff, 23'd0};
            spec_dz  = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done   <= 1'b0;
            result <= 32'd0;
            dz     <= 1'b0;
            inv    <= 1'b0;
            sign   <= 1'b0;
            exp_r  <= 10'sd0;
            mb     <= 24'd0;
            rem    <= 25'd0;
            q      <= 26'd0;
            cnt    <= 5'd0;
            mant   <= 24'd0;
`ifdef FP_DIVIDE_RNE_EN
            guard  <= 1'b0;
            sticky <= 1'b0;
`endif
            a_zero <= 1'b0;
            a_inf  <= 1'b0;
            a_nan  <= 1'b0;
            b_zero <= 1'b0;
            b_inf  <= 1'b0;
            b_nan  <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        sign   <= a[31] ^ b[31];
                        exp_r  <= $signed({2'b00, a[30:23]})
                                - $signed({2'b00, b[30:23]})
                                + 10'sd127;
                        mb     <= {1'b1, b[22:0]};
                        rem    <= {2'b01, a[22:0]};
                        q      <= 26'd0;
                        cnt    <= 5'd0;
                        a_zero <= a_zero_c;
                        a_inf  <= a_inf_c;
                        a_nan  <= a_nan_c;
                        b_zero <= b_zero_c;
                        b_inf  <= b_inf_c;
                        b_nan  <= b_nan_c;
                    end
                end
                SPECIAL: begin
                    result <= spec_res;
                    dz     <= spec_dz;
                    inv    <= spec_inv;
                    done   <= 1'b1;
                end
                DIV: begin
                    rem <= diff << 1;
                    q   <= {q[24:0], ge};
                    cnt <= cnt + 5'd1;
                end
                NORM: begin
                    if (q[25]) begin
                        mant   <= q[25:2];
`ifdef FP_DIVIDE_RNE_EN
                        guard  <= q[1];
                        sticky <= q[0] | (rem != 25'd0);
`endif
                    end else begin
                        mant   <= q[24:1];
`ifdef FP_DIVIDE_RNE_EN
                        guard  <= q[0];
                        sticky <= (rem != 25'd0);
`endif
                        exp_r  <= exp_r - 10'sd1;
                    end
                end
                ROUND: begin
                    result <= pack;
                    dz     <= 1'b0;
                    inv    <= 1'b0;
                    done   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/fp32_divide.md
# fp32_divide

Sequential IEEE-754 binary32 divider computing result = a / b, the inverse-operation companion to the combinational `multiply` block in the floating-point datapath. It uses a start/done handshake and restoring radix-2 mantissa division, one quotient bit per clock. Special operands resolve in one cycle. Subnormals are flushed to zero.

## Interface
- Parameters: none; the format is fixed to binary32 (8-bit exponent, bias 127, 23-bit fraction).
- clk  input  1  single clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  request. Sampled only when idle.
- a  input  32  dividend, binary32.
- b  input  32  divisor, binary32.
- busy  output  1  high whenever the FSM is not IDLE. Reset value 0.
- done  output  1  one-cycle pulse when result and flags update. Reset value 0.
- result  output  32  quotient. Holds until the next completion. Reset value 0x00000000.
- dz  output  1  divide-by-zero: finite nonzero / zero. Registered with result. Reset value 0.
- inv  output  1  invalid: NaN operand, 0/0 or inf/inf. Registered with result. Reset value 0.

## Operation
- **IDLE**
  - If start=1: register sign = a[31]^b[31], unpacked exponents and mantissas (hidden 1 prepended, 24 bits). Classify both operands.
  - If either operand is special, go to SPECIAL; otherwise go to DIV.
  - Any operand with exponent 0 is treated as zero, whatever its fraction.
- **SPECIAL** (one cycle, then back to IDLE with done=1). Rules in priority order:
  - NaN in, 0/0, or inf/inf → 0x7FC00000, inv=1.
  - inf/x → signed inf.
  - x/inf → signed zero.
  - nonzero/0 → signed inf, dz=1.
  - 0/x → signed zero.
- **DIV** (exactly 26 cycles)
  - Remainder is initialised to the dividend mantissa.
  - Each cycle: q bit = (rem >= mb); if set, rem -= mb; then rem <<= 1.
  - Produces 26 quotient bits q[25:0]; q[25] has weight 2^0.
  - Exponent = ea − eb + 127, held in 10-bit signed form.
- **NORM** (1 cycle)
  - If q[25]=1: mant=q[25:2], guard=q[1], sticky=q[0] | (rem≠0).
  - Otherwise: mant=q[24:1], guard=q[0], sticky=(rem≠0), and exponent −1.
- **ROUND** (1 cycle, then back to IDLE with done=1)
  - Apply rounding (see Configuration).
  - If the mantissa carries out of rounding: mant >>= 1, exponent +1.
  - Exponent ≥ 255 → signed inf (0x7F800000 | sign).
  - Exponent ≤ 0 → signed zero; no subnormal output.
  - Otherwise pack {sign, exp[7:0], mant[22:0]}.
  - dz=0 and inv=0 for every non-special result.

## Timing
- Latency is counted from the rising edge that samples start=1.
- Normal operands: done=1 in the cycle following edge 28 (26 DIV + NORM + ROUND).
- Special operands: done=1 in the cycle following edge 1.
- busy rises the cycle after start is sampled and falls in the same cycle done rises. The FSM is already IDLE when done is high.
- start asserted while busy is ignored; there is no queuing.
- start asserted in the done cycle is accepted, so back-to-back operations run at 29 cycles per op for normal operands.
- a and b need only be valid in the start cycle; they are not re-sampled.
- result, dz and inv change only on the done edge.
- rst asserted mid-operation:
  - FSM goes to IDLE immediately.
  - All outputs return to their reset values.
  - No done pulse is produced for the aborted operation.

## Configuration
- FP_DIVIDE_RNE_EN defined: round-to-nearest-even. Increment mant if guard & (sticky | mant[0]).
- FP_DIVIDE_RNE_EN undefined: round toward zero (truncate). Guard and sticky are discarded, and the ROUND state still takes one cycle so latency is identical in both builds.

## Test plan
- a=0x3FA00000 (1.25), b=0x3F400000 (0.75), start pulse → result=0x3FD55555, dz=0, inv=0. done exactly 28 cycles after the start edge; busy high for cycles 1..28.
- a=0x411C0000 (9.75), b=0xBF100000 (−0.5625):
  - with FP_DIVIDE_RNE_EN → result=0xC18AAAAB.
  - without → result=0xC18AAAAA.
- Specials, each with done 1 cycle after start:
  - a=0x3F800000, b=0x00000000 → 0x7F800000, dz=1.
  - a=0x00000000, b=0x00000000 → 0x7FC00000, inv=1.
  - a=0x7F800000, b=0xC0000000 → 0xFF800000, dz=0, inv=0.
- Range limits:
  - a=0x7F000000, b=0x3E800000 → 0x7F800000 (overflow).
  - a=0x00800000, b=0x40000000 → 0x00000000 (underflow flush).
- Handshake:
  - start re-pulsed at cycle 10 of an operation → ignored, single done.
  - start held high across the done cycle → second operation accepted; its done arrives 29 cycles after the first.
- Reset mid-operation: rst asserted at cycle 15 of 1.25/0.75 → busy=0, done=0 and result=0 immediately. No later done pulse until a new start.
